// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle sequencing FSM and the MIPS datapath.
// Latency: none (wires only). Backpressure: none; the datapath always follows the controller.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pcWriteEn;
    logic        IorD;
    logic        IRWrite;
    logic        memWrite;
    logic [1:0]  memToReg;
    logic [1:0]  regDst;
    logic        regWriteEnable;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [4:0]  ALUControl;
    logic        halted;
    logic [31:0] instrCount;

    modport master (
        input  opcode, funct, zero,
        output pcWriteEn, IorD, IRWrite, memWrite, memToReg, regDst,
               regWriteEnable, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
               halted, instrCount
    );

    modport slave (
        output opcode, funct, zero,
        input  pcWriteEn, IorD, IRWrite, memWrite, memToReg, regDst,
               regWriteEnable, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
               halted, instrCount
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle MIPS datapath, plus retired-instruction counter.
// Latency: 3-5 cycles per instruction (FETCH through terminal state); outputs follow state same cycle.
// Backpressure: none; the FSM advances every cycle and parks in HALT on unsupported instructions.
module multicycle_controller (
    input  logic                    clock,
    input  logic                    resetN,
    multicycle_controller_if.master ctl
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] MEMADR   = 4'd3;
    localparam logic [3:0] MEMREAD  = 4'd4;
    localparam logic [3:0] MEMWB    = 4'd5;
    localparam logic [3:0] MEMWRITE = 4'd6;
    localparam logic [3:0] EXECUTE  = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] ADDIEXEC = 4'd10;
    localparam logic [3:0] ADDIWB   = 4'd11;
    localparam logic [3:0] JUMP     = 4'd12;
    localparam logic [3:0] JR       = 4'd13;
    localparam logic [3:0] JAL      = 4'd14;
    localparam logic [3:0] HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    logic [3:0]  state;
    logic [3:0]  state_next;
    logic [4:0]  alu_op_q;
    logic [4:0]  alu_dec;
    logic        funct_ok;
    logic        terminal;
    logic [31:0] instr_count;

    always_comb begin
        funct_ok = 1'b1;
        alu_dec  = ALU_ADD;
        case (ctl.funct)
            6'b100000: alu_dec = ALU_ADD;
            6'b100010: alu_dec = ALU_SUB;
            6'b100100: alu_dec = ALU_AND;
            6'b100101: alu_dec = ALU_OR;
            6'b101010: alu_dec = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    assign terminal = (state == MEMWB)  || (state == MEMWRITE) || (state == ALUWB) ||
                      (state == BRANCH) || (state == ADDIWB)   || (state == JUMP)  ||
                      (state == JR)     || (state == JAL);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (ctl.opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        if (ctl.funct == FN_JR) state_next = JR;
                        else if (funct_ok)      state_next = EXECUTE;
                        else                    state_next = HALT;
                    end
                    OP_BEQ:  state_next = BRANCH;
                    OP_ADDI: state_next = ADDIEXEC;
                    OP_J:    state_next = JUMP;
                    OP_JAL:  state_next = JAL;
                    default: state_next = HALT;
                endcase
            end
            MEMADR:   state_next = (ctl.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    // The ALU op is latched in DECODE so EXECUTE outputs depend on registered state only.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            alu_op_q    <= ALU_ADD;
            instr_count <= 32'd0;
        end else begin
            state <= state_next;
            if (state == DECODE) alu_op_q <= alu_dec;
            if (terminal) instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        ctl.IorD           = 1'b0;
        ctl.IRWrite        = 1'b0;
        ctl.memWrite       = 1'b0;
        ctl.memToReg       = 2'b00;
        ctl.regDst         = 2'b00;
        ctl.regWriteEnable = 1'b0;
        ctl.ALUSrcA        = 1'b0;
        ctl.ALUSrcB        = 2'b00;
        ctl.PCSrc          = 2'b00;
        ctl.ALUControl     = ALU_ADD;
        case (state)
            IDLE, HALT: ctl.ALUControl = 5'b00000;
            FETCH:    begin ctl.IRWrite = 1'b1; ctl.ALUSrcB = 2'b01; end
            DECODE:   ctl.ALUSrcB = 2'b11;
            MEMADR:   begin ctl.ALUSrcA = 1'b1; ctl.ALUSrcB = 2'b10; end
            MEMREAD:  ctl.IorD = 1'b1;
            MEMWB:    begin ctl.memToReg = 2'b01; ctl.regWriteEnable = 1'b1; end
            MEMWRITE: begin ctl.IorD = 1'b1; ctl.memWrite = 1'b1; end
            EXECUTE:  begin ctl.ALUSrcA = 1'b1; ctl.ALUControl = alu_op_q; end
            ALUWB:    begin ctl.regDst = 2'b01; ctl.regWriteEnable = 1'b1; end
            BRANCH:   begin ctl.ALUSrcA = 1'b1; ctl.ALUControl = ALU_SUB; ctl.PCSrc = 2'b01; end
            ADDIEXEC: begin ctl.ALUSrcA = 1'b1; ctl.ALUSrcB = 2'b10; end
            ADDIWB:   ctl.regWriteEnable = 1'b1;
            JUMP:     ctl.PCSrc = 2'b10;
            JR:       ctl.PCSrc = 2'b11;
            JAL: begin
                ctl.PCSrc          = 2'b10;
                ctl.regDst         = 2'b10;
                ctl.memToReg       = 2'b10;
                ctl.regWriteEnable = 1'b1;
            end
            default: ;
        endcase
    end

    // zero is the only input allowed to reach an output combinationally.
    assign ctl.pcWriteEn  = (state == FETCH) || (state == JUMP) || (state == JR) ||
                            (state == JAL)   || ((state == BRANCH) && ctl.zero);
    assign ctl.halted     = (state == HALT);
    assign ctl.instrCount = instr_count;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multicycle MIPS datapath. It decodes the opcode and funct fields held in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback cycles. Every cycle it drives the datapath's mux selects, register enables, memory write enable and ALU operation code. It also keeps a retired-instruction counter and raises a sticky halt when it decodes an unsupported instruction.

## Interface
- No parameters.
- clock  in  1  rising-edge clock shared with the datapath.
- resetN  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26], taken from the instruction register.
- funct  in  6  instr[5:0], taken from the instruction register.
- zero  in  1  ALU result-is-zero flag, combinational from the ALU.
- pcWriteEn  out  1  PC register enable.
- IorD  out  1  memory address select: 0 = pcQ, 1 = ALUOut.
- IRWrite  out  1  instruction register enable.
- memWrite  out  1  memory write enable.
- memToReg  out  2  WD3 select: 00 = ALUOut, 01 = memory data register, 10 = pcQ.
- regDst  out  2  A3 select: 00 = rt, 01 = rd, 10 = register 31.
- regWriteEnable  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = pcQ, 1 = RDA.
- ALUSrcB  out  2  ALU B select: 00 = RDB, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = RD1.
- ALUControl  out  5  ALU operation: AND = 00000, OR = 00001, ADD = 00010, SUB = 00110, SLT = 00111.
- halted  out  1  sticky flag set on an unsupported instruction.
- instrCount  out  32  number of retired instructions.

## Operation
- The FSM is Moore style. Every output except pcWriteEn is decoded from the state register only.
- pcWriteEn = (state in {FETCH, JUMP, JR, JAL}) | (state == BRANCH & zero).
- In any state, outputs not listed for that state are 0, and ALUControl is ADD.
- State outputs:
  - IDLE: all outputs 0, ALUControl = 00000.
  - FETCH: IRWrite = 1, ALUSrcB = 01, PCSrc = 00 (PC <= PC + 4).
  - DECODE: ALUSrcB = 11 (branch target captured into ALUOut).
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10.
  - MEMREAD: IorD = 1.
  - MEMWB: memToReg = 01, regDst = 00, regWriteEnable = 1.
  - MEMWRITE: IorD = 1, memWrite = 1.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUControl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT).
  - ALUWB: regDst = 01, regWriteEnable = 1.
  - BRANCH: ALUSrcA = 1, ALUControl = SUB, PCSrc = 01.
  - ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10.
  - ADDIWB: regDst = 00, regWriteEnable = 1.
  - JUMP: PCSrc = 10.
  - JR: PCSrc = 11.
  - JAL: PCSrc = 10, regDst = 10, memToReg = 10, regWriteEnable = 1. pcQ already holds PC + 4 at this point.
  - HALT: all outputs 0.
- Transitions:
  - IDLE -> FETCH -> DECODE.
  - DECODE on opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE for the five ALU functs, JR for funct 001000, HALT for any other funct; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; 000011 -> JAL; any other opcode -> HALT.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw); MEMREAD -> MEMWB.
  - EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP, JR, JAL -> FETCH.
  - HALT -> HALT. Only reset leaves HALT.
- instrCount increments by 1 on every clock edge that leaves a terminal state (one of the eight states listed above as returning to FETCH). It wraps from 0xFFFFFFFF to 0. It never increments on entry to HALT.
- halted = 1 exactly while the state is HALT.

## Timing
- Reset: resetN low forces state to IDLE immediately (asynchronous), so every output is 0 and instrCount = 0, halted = 0.
- Reset asserted mid-instruction aborts the instruction with no further enables. The first FETCH occurs 1 cycle after resetN is released.
- Cycles per instruction, FETCH through terminal state: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; jal 3; jr 3.
- opcode and funct are sampled only in DECODE and MEMADR. The IR is written only in FETCH, so both fields are stable in those states.
- zero affects pcWriteEn combinationally in BRANCH only. A taken branch updates the PC on the BRANCH clock edge.

## Test plan
- Reset and start: hold resetN low for 3 cycles with clock running -> all outputs 0, instrCount = 0. Release -> IDLE for 1 cycle, FETCH next with IRWrite = 1 and pcWriteEn = 1.
- Sequence lw, sw, add (funct 100000) -> states visited FETCH, DECODE, MEMADR, MEMREAD, MEMWB; FETCH, DECODE, MEMADR, MEMWRITE; FETCH, DECODE, EXECUTE (ALUControl = 00010), ALUWB. instrCount = 3 after 13 cycles.
- beq with zero = 1 -> pcWriteEn = 1 in BRANCH with PCSrc = 01. Repeat with zero = 0 -> pcWriteEn = 0. instrCount increments in both cases.
- jal -> in JAL: regDst = 10, memToReg = 10, regWriteEnable = 1, pcWriteEn = 1, PCSrc = 10. jr (funct 001000) -> PCSrc = 11, regWriteEnable = 0.
- Opcode 111111 -> HALT after DECODE with halted = 1 and every enable 0 for 10+ cycles. R-type funct 000000 -> also HALT. instrCount is unchanged in both cases.
- Assert resetN in MEMREAD of a lw -> outputs go to 0 in the same cycle and instrCount = 0. After release, execution restarts with IDLE then FETCH.
